mult_share_ctrl: RTL
====================

# mult_share_ctrl

Round-robin scheduler that shares one multi-cycle 8x8 unsigned multiplier among NUM_REQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues exactly one operation at a time to the shared multiplier. It waits for the multiplier's done pulse, or times out, and returns the 16-bit product tagged with the requester index over a single response handshake. It sits between the client blocks and the shared multiplier datapath.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- ID_W, 2: width of the requester index; must equal ceil(log2(NUM_REQ)).
- TIMEOUT, 15: maximum cycles spent in WAIT before an error response; valid range 1..255.
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  request pending, one bit per requester.
- req_a  in  8*NUM_REQ  multiplicand; requester i uses bits [8i+7:8i].
- req_b  in  8*NUM_REQ  multiplier operand, same packing as req_a.
- req_ready  out  NUM_REQ  one-hot grant/accept.
- mul_start  out  1  one-cycle start pulse to the shared multiplier.
- mul_a  out  8  operand A, held stable from the start pulse until the op ends.
- mul_b  out  8  operand B, held stable the same way.
- mul_done  in  1  multiplier completion pulse.
- mul_result  in  16  product; sampled only in the cycle mul_done=1.
- rsp_valid  out  1  response available.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_result  out  16  product; 0 on error.
- rsp_err  out  1  1 = the multiplier timed out.
- rsp_ready  in  1  consumer accepts the response.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, grant the first set bit searching upward from rr_ptr with wrap-around.
  - req_ready[g]=1 combinationally in that same cycle. The transfer completes in this cycle.
  - Latch req_a/req_b slice g into mul_a/mul_b and g into rsp_id.
  - Set rr_ptr <= (g+1) mod NUM_REQ, then go to ISSUE.
  - With no request pending, stay in IDLE; rr_ptr is unchanged.
- ISSUE:
  - mul_start=1 for exactly this cycle.
  - Clear the timeout counter, then go to WAIT.
- WAIT:
  - Increment the timeout counter each cycle.
  - On mul_done=1: latch mul_result into rsp_result, set rsp_err=0, go to RESP.
  - Otherwise, if the counter reaches TIMEOUT: set rsp_result=0, rsp_err=1, go to RESP.
  - If mul_done and the timeout occur in the same cycle, mul_done wins.
- RESP:
  - rsp_valid=1; rsp_id, rsp_result and rsp_err are held stable.
  - When rsp_ready=1, the response is consumed and the state returns to IDLE.
  - No new request is granted in that consume cycle; the earliest next grant is the following cycle.
- mul_done outside WAIT is ignored, including a late done after a timeout. mul_result is not sampled then.
- req_ready is all-zero in every state other than IDLE.
- req_a/req_b are sampled only in the grant cycle; later changes have no effect on the active op.
- Widths:
  - The product is passed through unmodified at 16 bits.
  - The counter is 8 bits; it saturates and never wraps.

## Timing
- Reset values: state=IDLE, rr_ptr=0, req_ready=0, mul_start=0, mul_a=0, mul_b=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, counter=0.
- Reset asserted mid-operation returns the block to IDLE on the next edge.
  - Any in-flight op is dropped with no response.
  - A mul_done arriving after reset is ignored.
- Timeline, with grant at cycle 0 and mul_done at cycle D:
  - mul_start in cycle 1.
  - WAIT from cycle 2.
  - rsp_valid from cycle D+1.
  - With rsp_ready held high: back in IDLE at D+2, next grant possible at D+2.
- Timeout: the counter is 1 in the first WAIT cycle. If mul_done never arrives, rsp_valid with rsp_err=1 rises in cycle TIMEOUT+2.
- Throughput: one op at a time. Minimum 4 cycles per op (IDLE, ISSUE, WAIT with same-cycle done, RESP).
- Fairness: any requester holding req_valid is granted within NUM_REQ grants.

## Test plan
- Single op: reset, then requester 2 sends a=13, b=11; the multiplier model returns done 5 cycles after mul_start.
  - Expect req_ready=4'b0100 in the grant cycle.
  - Expect exactly one mul_start pulse, with mul_a=13 and mul_b=11.
  - Expect rsp_valid with rsp_id=2, rsp_result=143, rsp_err=0.
- Round-robin: all four requesters hold valid continuously, with a=i+1 and b=255.
  - Expect grant order 0,1,2,3,0.
  - Expect results 255, 510, 765, 1020, 255.
- Extreme operands: a=255, b=255 gives rsp_result=65025. a=0, b=200 gives 0.
- Timeout with TIMEOUT=15: the model never asserts done.
  - Expect rsp_err=1 and rsp_result=0 in cycle 17 after the grant.
  - A late done injected afterwards produces no second response.
- Backpressure: rsp_ready is held low for 10 cycles.
  - rsp_valid and the response fields stay stable throughout.
  - req_ready stays 0 and there is no mul_start.
  - Releasing rsp_ready lets the next grant happen one cycle later.
- Reset mid-WAIT: assert reset for 1 cycle during WAIT.
  - All outputs return to reset values.
  - A subsequent mul_done is ignored; rsp_valid stays 0.
  - The next request is granted starting from requester 0.

Source files
------------

// File: rtl/mult_share_ctrl_if.sv
// Bundle of the requester, shared-multiplier and response handshakes of mult_share_ctrl.
// The master modport is the scheduler's view; slave is the surrounding environment.
interface mult_share_ctrl_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_a;
    logic [8*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]   req_ready;

    logic                 mul_start;
    logic [7:0]           mul_a;
    logic [7:0]           mul_b;
    logic                 mul_done;
    logic [15:0]          mul_result;

    logic                 rsp_valid;
    logic [ID_W-1:0]      rsp_id;
    logic [15:0]          rsp_result;
    logic                 rsp_err;
    logic                 rsp_ready;

    modport master (
        input  req_valid, req_a, req_b, mul_done, mul_result, rsp_ready,
        output req_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_id, rsp_result, rsp_err
    );

    modport slave (
        output req_valid, req_a, req_b, mul_done, mul_result, rsp_ready,
        input  req_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_id, rsp_result, rsp_err
    );
endinterface

// File: rtl/mult_share_ctrl.sv
// Round-robin scheduler sharing one multi-cycle 8x8 multiplier among NUM_REQ requesters,
// with a saturating timeout while waiting for the multiplier's done pulse.
module mult_share_ctrl #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    mult_share_ctrl_if.master bus
);
    localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]      mul_a_q, mul_a_d;
    logic [7:0]      mul_b_q, mul_b_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [15:0]     rsp_result_q, rsp_result_d;
    logic            rsp_err_q, rsp_err_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      cnt_inc;

    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] scan_idx;
    logic [7:0]      slice_a [NUM_REQ];
    logic [7:0]      slice_b [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign slice_a[i] = bus.req_a[8*i +: 8];
        assign slice_b[i] = bus.req_b[8*i +: 8];
    end

    // Scan from the highest offset down so the nearest requester at or after rr_ptr wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            scan_idx = ID_W'((int'(rr_ptr_q) + k) % int'(NUM_REQ));
            if (bus.req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    assign cnt_inc = (cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    mul_a_d  = slice_a[grant_idx];
                    mul_b_d  = slice_b[grant_idx];
                    rsp_id_d = grant_idx;
                    rr_ptr_d = ID_W'((int'(grant_idx) + 1) % int'(NUM_REQ));
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_inc;
                // A done in the timeout cycle still delivers the real product.
                if (bus.mul_done) begin
                    rsp_result_d = bus.mul_result;
                    rsp_err_d    = 1'b0;
                    state_d      = StResp;
                end else if (cnt_inc >= TimeoutVal) begin
                    rsp_result_d = '0;
                    rsp_err_d    = 1'b1;
                    state_d      = StResp;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.req_ready  = (state_q == StIdle && grant_found) ? (NUM_REQ'(1) << grant_idx) : '0;
    assign bus.mul_start  = (state_q == StIssue);
    assign bus.mul_a      = mul_a_q;
    assign bus.mul_b      = mul_b_q;
    assign bus.rsp_valid  = (state_q == StResp);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_err    = rsp_err_q;
endmodule
